// File: rtl/fd_pkg.sv
// Shared face-detect definitions: frame geometry, pixel layout, skin thresholds
// and the bounding-box FSM state type.
package fd_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  localparam int unsigned RGB_W = 12;
  localparam int unsigned POS_W = 10;
  localparam int unsigned CNT_W = 19;

  localparam int unsigned R_LSB = 8;
  localparam int unsigned G_LSB = 4;
  localparam int unsigned B_LSB = 0;

  localparam logic [3:0] R_MIN_DEF    = 4'd6;
  localparam logic [3:0] DIFF_MIN_DEF = 4'd2;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    ARM,
    ACCUM,
    LATCH
  } state_e;

endpackage

// File: rtl/skin_classifier.sv
// Combinational RGB444 skin test: red dominant, bright enough, and clearly redder than green.
module skin_classifier
  import fd_pkg::*;
#(
  parameter logic [3:0] R_MIN    = R_MIN_DEF,
  parameter logic [3:0] DIFF_MIN = DIFF_MIN_DEF
) (
  input  logic [RGB_W-1:0] rgb,
  output logic             skin_c
);

  rgb444_t    px;
  logic [3:0] diff;

  always_comb begin
    px     = '{r: rgb[R_LSB +: 4], g: rgb[G_LSB +: 4], b: rgb[B_LSB +: 4]};
    // r-g only meaningful when r>g; forcing 0 otherwise avoids wraparound
    diff   = (px.r > px.g) ? (px.r - px.g) : 4'd0;
    skin_c = (px.r > px.g) && (px.r > px.b) && (px.r >= R_MIN) && (diff >= DIFF_MIN);
  end

endmodule

// File: rtl/skin_bbox_detector.sv
// Per-frame skin bounding box: accumulates over a frame, publishes at vsync fall,
// and overlays the published box border on the pixel stream with one cycle latency.
module skin_bbox_detector
  import fd_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = fd_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE   = fd_pkg::V_ACTIVE,
  parameter logic [3:0]  R_MIN      = R_MIN_DEF,
  parameter logic [3:0]  DIFF_MIN   = DIFF_MIN_DEF,
  parameter logic [18:0] MIN_PIXELS = 19'd256,
  parameter logic [11:0] BOX_COLOR  = 12'h0F0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic             valid_in,
  input  logic             vsync,
  input  logic             overlay_en,
  output logic [RGB_W-1:0] rgb_out,
  output logic             valid_out,
  output logic             box_valid,
  output logic [POS_W-1:0] box_x_min,
  output logic [POS_W-1:0] box_x_max,
  output logic [POS_W-1:0] box_y_min,
  output logic [POS_W-1:0] box_y_max,
  output logic [CNT_W-1:0] skin_count
);

  localparam logic [POS_W-1:0] X_LAST  = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] Y_LAST  = POS_W'(V_ACTIVE - 1);
  localparam logic [POS_W-1:0] MIN_INIT = '1;

  state_e             state_q, state_d;
  logic               vsync_q, valid_q, fb_q, fb_d;
  logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
  logic [POS_W-1:0]   acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [POS_W-1:0]   acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [POS_W-1:0]   bx_min_q, bx_min_d, bx_max_q, bx_max_d;
  logic [POS_W-1:0]   by_min_q, by_min_d, by_max_q, by_max_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bvalid_q, bvalid_d;
  logic [RGB_W-1:0]   rgb_out_q, rgb_out_d;
  logic               valid_out_q, valid_out_d;
  logic               skin_c, in_x_c, in_y_c, border_c;

  skin_classifier #(.R_MIN(R_MIN), .DIFF_MIN(DIFF_MIN)) u_cls (
    .rgb    (rgb_in),
    .skin_c (skin_c)
  );

  always_comb begin
    fb_d        = vsync_q & ~vsync;
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    acc_xmin_d  = acc_xmin_q;
    acc_xmax_d  = acc_xmax_q;
    acc_ymin_d  = acc_ymin_q;
    acc_ymax_d  = acc_ymax_q;
    acc_cnt_d   = acc_cnt_q;
    bx_min_d    = bx_min_q;
    bx_max_d    = bx_max_q;
    by_min_d    = by_min_q;
    by_max_d    = by_max_q;
    cnt_d       = cnt_q;
    bvalid_d    = bvalid_q;

    // position counters; the registered boundary and LATCH both restart them
    if (fb_q || (state_q == LATCH)) begin
      x_d = '0;
      y_d = '0;
    end else if (valid_in) begin
      if (x_q != X_LAST) x_d = x_q + POS_W'(1);
    end else if (valid_q) begin
      x_d = '0;
      if (y_q != Y_LAST) y_d = y_q + POS_W'(1);
    end

    case (state_q)
      ARM: begin
        if (fb_q) begin
          acc_xmin_d = MIN_INIT;
          acc_xmax_d = '0;
          acc_ymin_d = MIN_INIT;
          acc_ymax_d = '0;
          acc_cnt_d  = '0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (valid_in && skin_c) begin
          if (x_q < acc_xmin_q) acc_xmin_d = x_q;
          if (x_q > acc_xmax_q) acc_xmax_d = x_q;
          if (y_q < acc_ymin_q) acc_ymin_d = y_q;
          if (y_q > acc_ymax_q) acc_ymax_d = y_q;
          if (acc_cnt_q != '1) acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
        if (fb_q) state_d = LATCH;
      end
      LATCH: begin
        bx_min_d   = acc_xmin_q;
        bx_max_d   = acc_xmax_q;
        by_min_d   = acc_ymin_q;
        by_max_d   = acc_ymax_q;
        cnt_d      = acc_cnt_q;
        bvalid_d   = (acc_cnt_q >= MIN_PIXELS);
        acc_xmin_d = MIN_INIT;
        acc_xmax_d = '0;
        acc_ymin_d = MIN_INIT;
        acc_ymax_d = '0;
        acc_cnt_d  = '0;
        state_d    = ACCUM;
      end
      default: state_d = ARM;
    endcase

    // overlay against the published (previous frame) box
    in_x_c      = (x_q >= bx_min_q) && (x_q <= bx_max_q);
    in_y_c      = (y_q >= by_min_q) && (y_q <= by_max_q);
    border_c    = bvalid_q && overlay_en &&
                  ((((x_q == bx_min_q) || (x_q == bx_max_q)) && in_y_c) ||
                   (((y_q == by_min_q) || (y_q == by_max_q)) && in_x_c));
    valid_out_d = valid_in;
    rgb_out_d   = valid_in ? (border_c ? BOX_COLOR : rgb_in) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARM;
      vsync_q     <= 1'b0;
      valid_q     <= 1'b0;
      fb_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      acc_xmin_q  <= MIN_INIT;
      acc_xmax_q  <= '0;
      acc_ymin_q  <= MIN_INIT;
      acc_ymax_q  <= '0;
      acc_cnt_q   <= '0;
      bx_min_q    <= '0;
      bx_max_q    <= '0;
      by_min_q    <= '0;
      by_max_q    <= '0;
      cnt_q       <= '0;
      bvalid_q    <= 1'b0;
      rgb_out_q   <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      valid_q     <= valid_in;
      fb_q        <= fb_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_xmin_q  <= acc_xmin_d;
      acc_xmax_q  <= acc_xmax_d;
      acc_ymin_q  <= acc_ymin_d;
      acc_ymax_q  <= acc_ymax_d;
      acc_cnt_q   <= acc_cnt_d;
      bx_min_q    <= bx_min_d;
      bx_max_q    <= bx_max_d;
      by_min_q    <= by_min_d;
      by_max_q    <= by_max_d;
      cnt_q       <= cnt_d;
      bvalid_q    <= bvalid_d;
      rgb_out_q   <= rgb_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign rgb_out    = rgb_out_q;
  assign valid_out  = valid_out_q;
  assign box_valid  = bvalid_q;
  assign box_x_min  = bx_min_q;
  assign box_x_max  = bx_max_q;
  assign box_y_min  = by_min_q;
  assign box_y_max  = by_max_q;
  assign skin_count = cnt_q;

endmodule

// File: tb/tb_skin_bbox_detector.sv
// Directed bench for skin_bbox_detector on a reduced 40x30 frame.
module tb_skin_bbox_detector;

  localparam int HA = 40;
  localparam int VA = 30;

  logic        clk = 1'b0;
  logic        rst_n, valid_in, vsync, overlay_en;
  logic [11:0] rgb_in, rgb_out;
  logic        valid_out, box_valid;
  logic [9:0]  box_x_min, box_x_max, box_y_min, box_y_max;
  logic [18:0] skin_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic       exp_bv = 1'b0;
  logic [9:0] ex0 = '0, ex1 = '0, ey0 = '0, ey1 = '0;

  always #20 clk = ~clk;

  skin_bbox_detector #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rgb_in     (rgb_in),
    .valid_in   (valid_in),
    .vsync      (vsync),
    .overlay_en (overlay_en),
    .rgb_out    (rgb_out),
    .valid_out  (valid_out),
    .box_valid  (box_valid),
    .box_x_min  (box_x_min),
    .box_x_max  (box_x_max),
    .box_y_min  (box_y_min),
    .box_y_max  (box_y_max),
    .skin_count (skin_count)
  );

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_box(input string tag, input logic bv, input int cnt,
                           input int x0, input int x1, input int y0, input int y1);
    check({tag, "_valid"}, 32'(box_valid), 32'(bv));
    check({tag, "_count"}, 32'(skin_count), 32'(cnt));
    check({tag, "_xmin"},  32'(box_x_min), 32'(x0));
    check({tag, "_xmax"},  32'(box_x_max), 32'(x1));
    check({tag, "_ymin"},  32'(box_y_min), 32'(y0));
    check({tag, "_ymax"},  32'(box_y_max), 32'(y1));
  endtask

  function automatic logic [11:0] pix(input int pat, input int x, input int y);
    case (pat)
      0:       return 12'h444;
      1:       return (x >= 10 && x <= 29 && y >= 5 && y <= 20) ? 12'hA53 : 12'h222;
      2:       return (x >= 3 && x <= 17 && y >= 3 && y <= 17) ? 12'hA53 : 12'h222;
      3:       return (x >= 3 && x <= 18 && y >= 3 && y <= 18) ? 12'hA53 : 12'h222;
      default: return 12'h222;
    endcase
  endfunction

  function automatic logic [11:0] exp_pix(input logic [11:0] c, input int x, input int y);
    logic on;
    on = exp_bv && overlay_en &&
         ((((x == int'(ex0)) || (x == int'(ex1))) && y >= int'(ey0) && y <= int'(ey1)) ||
          (((y == int'(ey0)) || (y == int'(ey1))) && x >= int'(ex0) && x <= int'(ex1)));
    return on ? 12'h0F0 : c;
  endfunction

  // Lines of nx pixels plus a 4-cycle gap; corner=1 drops vsync with the very last pixel.
  task automatic drive_frame(input int pat, input int nlines, input int nx,
                             input bit chk, input bit corner);
    logic [11:0] c;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < nx; x++) begin
        c = pix(pat, x, y);
        if (corner && y == nlines - 1 && x == nx - 1) begin
          c     = 12'hA53;
          vsync = 1'b0;
        end
        rgb_in   = c;
        valid_in = 1'b1;
        step();
        if (chk) begin
          check("pix_rgb", 32'(rgb_out), 32'(exp_pix(c, x, y)));
          check("pix_valid", 32'(valid_out), 32'd1);
        end
      end
      valid_in = 1'b0;
      rgb_in   = 12'(($urandom % 4095) + 1);
      step();
      if (chk) begin
        check("gap_rgb", 32'(rgb_out), 32'd0);
        check("gap_valid", 32'(valid_out), 32'd0);
      end
      repeat (3) step();
    end
    if (corner) begin
      vsync = 1'b1;
      repeat (2) step();
    end
  endtask

  task automatic boundary();
    vsync = 1'b0;
    repeat (3) step();
    vsync = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    rst_n      = 1'b0;
    vsync      = 1'b1;
    valid_in   = 1'b0;
    rgb_in     = 12'h000;
    overlay_en = 1'b0;
    #50;
    check("rst_rgb", 32'(rgb_out), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check_box("rst", 1'b0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();

    // skin before the first boundary is discarded
    drive_frame(1, VA, HA, 1'b0, 1'b0);
    boundary();
    check_box("first", 1'b0, 0, 0, 0, 0, 0);

    // no-skin frame: passthrough with 1-cycle latency
    overlay_en = 1'b1;
    drive_frame(0, VA, HA, 1'b1, 1'b0);
    boundary();
    check_box("noskin", 1'b0, 0, 10'h3FF, 0, 10'h3FF, 0);

    // square frame, with boundary latency check
    drive_frame(1, VA, HA, 1'b0, 1'b0);
    vsync = 1'b0;
    step();
    check("lat_e0", 32'(box_x_min), 32'h3FF);
    step();
    check("lat_e1", 32'(box_x_min), 32'h3FF);
    step();
    check("lat_e2", 32'(box_x_min), 32'd10);
    vsync = 1'b1;
    repeat (2) step();
    check_box("square", 1'b1, 320, 10, 29, 5, 20);
    exp_bv = 1'b1; ex0 = 10'd10; ex1 = 10'd29; ey0 = 10'd5; ey1 = 10'd20;

    // overlay on, then off
    overlay_en = 1'b1;
    drive_frame(1, VA, HA, 1'b1, 1'b0);
    boundary();
    check_box("square2", 1'b1, 320, 10, 29, 5, 20);
    overlay_en = 1'b0;
    drive_frame(1, VA, HA, 1'b1, 1'b0);
    boundary();
    check_box("square3", 1'b1, 320, 10, 29, 5, 20);

    // threshold: 225 below, 256 at minimum
    drive_frame(2, VA, HA, 1'b0, 1'b0);
    boundary();
    check_box("patch15", 1'b0, 225, 3, 17, 3, 17);
    exp_bv = 1'b0; ex0 = 10'd3; ex1 = 10'd17; ey0 = 10'd3; ey1 = 10'd17;
    overlay_en = 1'b1;
    drive_frame(3, VA, HA, 1'b1, 1'b0);
    boundary();
    check_box("patch16", 1'b1, 256, 3, 18, 3, 18);

    // oversize frame: x,y saturate; skin pixel coincident with the boundary
    drive_frame(4, VA + 2, HA + 5, 1'b0, 1'b1);
    check_box("corner", 1'b0, 1, HA - 1, HA - 1, VA - 1, VA - 1);

    // asynchronous reset mid-frame
    drive_frame(1, 12, HA, 1'b0, 1'b0);
    #5 rst_n = 1'b0;
    #1;
    check("midrst_rgb", 32'(rgb_out), 32'd0);
    check("midrst_valid_out", 32'(valid_out), 32'd0);
    check_box("midrst", 1'b0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    drive_frame(1, VA, HA, 1'b0, 1'b0);
    boundary();
    check_box("postrst_arm", 1'b0, 0, 0, 0, 0, 0);
    drive_frame(1, VA, HA, 1'b0, 1'b0);
    boundary();
    check_box("postrst", 1'b1, 320, 10, 29, 5, 20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
